// File: rtl/ram8_fifo_ctrl_pkg.sv
// rtl/ram8_fifo_ctrl_pkg.sv - shared constants for the RAM8-backed FIFO controller
package fifo_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;

   localparam logic [ADDR_W:0] FULL_COUNT = ADDR_W'(0) + (ADDR_W+1)'(DEPTH);

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/ram8_fifo_ctrl_if.sv
// rtl/ram8_fifo_ctrl_if.sv - producer/consumer valid-ready stream bundle
interface ram8_fifo_ctrl_if;
   import fifo_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/ram8_fifo_ctrl.sv
// rtl/ram8_fifo_ctrl.sv - valid/ready FIFO controller owning every RAM8 access
module ram8_fifo_ctrl
   import fifo_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   ram8_fifo_ctrl_if.slave   bus,
   output logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_en,
   output logic              ram_rw,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;

   logic w_do_read;
   logic w_do_write;
   logic w_in_ready;

   // Reads win the single RAM port; a colliding push is stalled via in_ready.
   always_comb begin
      w_do_read  = 1'b0;
      w_in_ready = 1'b0;
      w_do_write = 1'b0;
      w_do_read  = !flush && (r_count != '0) && (!r_out_valid || bus.out_ready);
      w_in_ready = rst_n && !flush && (r_count != FULL_COUNT) && !w_do_read;
      w_do_write = bus.in_valid && w_in_ready;
   end

   assign ram_en    = w_do_read || w_do_write;
   assign ram_rw    = w_do_write ? RW_WRITE : RW_READ;
   assign ram_addr  = w_do_write ? r_wr_ptr : r_rd_ptr;
   assign ram_wdata = bus.in_data;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign count         = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_do_write) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            r_count  <= r_count + (ADDR_W+1)'(1);
         end
         if (w_do_read) begin
            r_out_data  <= ram_rdata;
            r_out_valid <= 1'b1;
            r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
            r_count     <= r_count - (ADDR_W+1)'(1);
         end else if (bus.out_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/ram8_fifo_ctrl.md
Name: ram8_fifo_ctrl

Overview:
- Valid/ready FIFO controller that uses the existing 8-entry x 16-bit single-port RAM8 as its storage.
- Generates the RAM's address, enable and read/write strobe from a write pointer, a read pointer and an occupancy counter.
- Captures read data into a registered output stage.
- Sits between a streaming producer and consumer, directly upstream of the RAM8 instance, and owns every RAM8 access.

Parameters:
- DATA_W, 16, data width; must match the RAM8 word width.
- ADDR_W, 3, RAM address width; RAM depth is 2**ADDR_W = 8.

Ports:
- clk  input  1  rising-edge clock, shared with RAM8
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all contents
- in_valid  input  1  producer has data
- in_data  input  DATA_W  producer data
- in_ready  output  1  controller accepts in_data this cycle
- out_valid  output  1  out_data holds a valid word
- out_data  output  DATA_W  registered head-of-queue word
- out_ready  input  1  consumer takes out_data this cycle
- count  output  ADDR_W+1  words held in RAM, 0..8; excludes the output register
- ram_addr  output  ADDR_W  to RAM8 address
- ram_en  output  1  to RAM8 en
- ram_rw  output  1  to RAM8 rw; 1 = write, 0 = read
- ram_wdata  output  DATA_W  to RAM8 in
- ram_rdata  input  DATA_W  from RAM8 out; combinationally valid in the cycle of a read access

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0.
- While reset is asserted, combinational outputs are: ram_en=0, ram_rw=0, in_ready=0.
- Reset mid-operation discards all data; RAM contents are not cleared and are ignored afterwards.
- Single-port rule: at most one RAM access per cycle.
  - do_read = (count != 0) && (!out_valid || out_ready)
  - do_write = in_valid && in_ready
  - in_ready = (count != 8) && !do_read; this is combinational and depends on out_ready.
- Read has priority. A simultaneous push is stalled (in_ready=0), never dropped.
- RAM drive, all combinational:
  - ram_en = do_read | do_write
  - ram_rw = do_write
  - ram_addr = do_write ? wr_ptr : rd_ptr
  - ram_wdata = in_data
- Clock edge, write: wr_ptr+1, with natural 3-bit wrap 7->0.
- Clock edge, read: out_data <= ram_rdata, out_valid <= 1, rd_ptr+1 with wrap.
- Clock edge, out_ready && out_valid && !do_read: out_valid <= 0; out_data holds its value.
- count: +1 on write, -1 on read. The two never occur in the same cycle.
- Total capacity is 9 words: 8 in RAM plus 1 in the output register.
- Latency, no bypass:
  - A word accepted at edge N is written at edge N.
  - If it is at the head, it is read at edge N+1.
  - out_valid is high from N+1 onward, giving a minimum 2-cycle push-to-out latency.
- Full (count==8): in_ready=0; in_valid is ignored without loss.
- Empty (count==0, out_valid=0): out_data holds its last value; no RAM access unless writing.
- out_data must be stable while out_valid && !out_ready.
- flush (sampled at the edge) overrides any access that edge and sets pointers, count and out_valid to 0. While flush=1, in_ready=0 and ram_en=0.

Decomposition:
- Shared package fifo_pkg holds:
  - constants DATA_W=16, ADDR_W=3, DEPTH=8
  - encodings RW_READ=0 and RW_WRITE=1
- No sub-module. Pointer/count logic and the output register stay in one block.
- RAM8 is instantiated by the parent, not inside this controller.

Test Plan:
- Reset: hold rst_n=0 while driving in_valid=1 -> count=0, out_valid=0, out_data=0, ram_en=0, in_ready=0. Release -> in_ready=1 next cycle.
- Single word: push 0xA5A5 at edge 1 with out_ready=0 -> ram_rw=1 and ram_addr=0 at edge 1; read at edge 2; out_valid=1, out_data=0xA5A5, count=0 after edge 2.
- Fill: with out_ready=0, push 0x0001..0x0009 -> 9 words accepted (1 in the output register, count=8), then in_ready=0. The 10th word is held and not lost.
- Drain order and wrap: after fill, set out_ready=1 with continuous pushes -> outputs appear strictly in push order. ram_addr wraps 7->0 for both pointers; no duplicates and no gaps over 20 words.
- Collision: count=3, out_valid=1, out_ready=1, in_valid=1 -> in_ready=0 that cycle and a read occurs. On the next cycle the push is accepted (ram_rw=1), provided out_ready=0 or another read is not pending.
- Flush and async reset: flush with count=5 -> count=0, out_valid=0 next edge. Then push 0x1234 -> it lands at ram_addr=0. Asserting rst_n low between edges forces out_valid=0 immediately.
